// File: rtl/uart_serial_rx_pkg.sv
// Shared types for the pad-side UART receiver: FSM states, FIFO entry layout
// and the parity helper.
package uart_serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       frame_err;
    logic       parity_err;
  } rx_entry_t;

  localparam int RX_ENTRY_W = 10;

  // Nonzero result flags a parity error; odd parity inverts the even check.
  function automatic logic parity_error(input logic [7:0] data, input logic pbit,
                                        input logic odd);
    return (^data) ^ pbit ^ odd;
  endfunction

endpackage

// File: rtl/uart_serial_rx_fifo.sv
// Small synchronous FIFO of received entries; head is visible combinationally
// so a freshly written byte is presented the cycle after the write.
module uart_serial_rx_fifo
  import uart_serial_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  rx_entry_t wdata,
  input  logic      pop,
  output rx_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  rx_entry_t      mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic           do_push;
  logic           do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A simultaneous pop frees the head slot, so a push into a full FIFO succeeds.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_serial_rx.sv
// UART 8N1 serial receiver with optional parity (macro UART_SERIAL_RX_PARITY_EN),
// mid-bit sampling, break handling and a small receive FIFO with overrun flag.
module uart_serial_rx
  import uart_serial_rx_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [7:0]           rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  logic                 sync1_reg, sync2_reg, rxs;
  rx_state_e            state_reg, state_next;
  logic [DIV_WIDTH-1:0] div_reg, div_next;
  logic [DIV_WIDTH-1:0] cnt_reg, cnt_next;
  logic [2:0]           bit_reg, bit_next;
  logic [7:0]           shreg_reg, shreg_next;
  logic                 perr_reg, perr_next;
  logic                 tick, push, pop, push_drop, par_active;
  logic                 fifo_full, fifo_empty, overrun_reg;
  rx_entry_t            push_entry, head;

`ifdef UART_SERIAL_RX_PARITY_EN
  assign par_active = parity_en;
`else
  logic unused_parity;
  assign par_active    = 1'b0;
  assign unused_parity = parity_en ^ parity_odd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= rxd;
      sync2_reg <= sync1_reg;
    end
  end
  assign rxs = sync2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shreg_reg <= '0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shreg_reg <= shreg_next;
      perr_reg  <= perr_next;
    end
  end

  assign tick = (cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    cnt_next   = tick ? (div_reg - DIV_WIDTH'(1)) : (cnt_reg - DIV_WIDTH'(1));
    bit_next   = bit_reg;
    shreg_next = shreg_reg;
    perr_next  = perr_reg;
    push       = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = cnt_reg;
        if (!rxs) begin
          // The counter holds clocks remaining before the sample edge, so the
          // half-bit load is one short to land the start sample at D/2.
          div_next   = divisor;
          cnt_next   = (divisor >> 1) - DIV_WIDTH'(1);
          perr_next  = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          bit_next   = '0;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_next = {rxs, shreg_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = par_active ? PARITY : STOP;
        end
      end
`ifdef UART_SERIAL_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          perr_next  = parity_error(shreg_reg, rxs, parity_odd);
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          push       = 1'b1;
          state_next = rxs ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_next = cnt_reg;
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign push_entry = '{data: shreg_reg, frame_err: !rxs, parity_err: perr_reg};
  assign pop        = rx_valid && rx_ready;
  assign push_drop  = push && fifo_full && !pop;

  uart_serial_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(push_entry),
    .pop  (pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Setting the sticky overrun flag has priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)              overrun_reg <= 1'b0;
    else if (push_drop)   overrun_reg <= 1'b1;
    else if (overrun_clr) overrun_reg <= 1'b0;
  end

  assign rx_valid      = !fifo_empty;
  assign rx_data       = rx_valid ? head.data : 8'h00;
  assign rx_frame_err  = rx_valid && head.frame_err;
  assign rx_parity_err = rx_valid && head.parity_err;
  assign overrun       = overrun_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_serial_rx.sv
// Directed bench for uart_serial_rx: table of frames plus hand-written corner
// sequences (glitch, break, overrun, mid-frame reset, optional parity).
module tb_uart_serial_rx;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic [DW-1:0] divisor = 16'd8;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_frame_err, rx_parity_err, rx_valid;
  logic          rx_ready = 1'b1;
  logic          overrun;
  logic          overrun_clr = 1'b0;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  uart_serial_rx #(.DIV_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .divisor(divisor),
    .parity_en(parity_en), .parity_odd(parity_odd),
    .rx_data(rx_data), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
    .overrun_clr(overrun_clr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every rising edge of rx_valid is logged with the head entry and cycle.
  typedef struct {
    int         at;
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } obs_t;
  obs_t obs_q[$];
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) prev_valid <= 1'b0;
    else begin
      if (rx_valid && !prev_valid)
        obs_q.push_back('{cyc, rx_data, rx_frame_err, rx_parity_err});
      prev_valid <= rx_valid;
    end
  end

  typedef struct {
    int         dv;
    logic [7:0] data;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
    int         exp_lat;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else
      $display("[TB] ok   %s = 0x%0h", name, act);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    idle(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic with_par,
                            input logic pbit, input int dv, output int t0);
    divisor = DW'(dv);
    t0 = cyc + 1;
    drive_bit(1'b0, dv);
    for (int k = 0; k < 8; k++) drive_bit(d[k], dv);
    if (with_par) drive_bit(pbit, dv);
    drive_bit(stop_bit, dv);
  endtask

  task automatic wait_entries(input int n, input int budget);
    int waited = 0;
    while (obs_q.size() < n && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (obs_q.size() < n) check("entry_timeout", obs_q.size(), n);
  endtask

  initial begin
    int    t0s[6];
    int    t0;
    obs_t  o;

    vecs[0] = '{8,  8'h55, 0,  8'h55, 1'b0, 1'b0, 78};
    vecs[1] = '{8,  8'hA3, 12, 8'hA3, 1'b0, 1'b0, 78};
    vecs[2] = '{5,  8'h00, 10, 8'h00, 1'b0, 1'b0, 49};
    vecs[3] = '{16, 8'hFF, 10, 8'hFF, 1'b0, 1'b0, 154};
    vecs[4] = '{8,  8'h80, 0,  8'h80, 1'b0, 1'b0, 78};
    vecs[5] = '{8,  8'h01, 10, 8'h01, 1'b0, 1'b0, 78};

    idle(4);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_frame_err", rx_frame_err, 1'b0);
    check("reset_parity_err", rx_parity_err, 1'b0);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_busy", busy, 1'b0);
    idle(2);

    // Table of frames; gap 0 means the next start bit follows the stop bit directly.
    obs_q.delete();
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, 1'b1, 1'b0, 1'b0, vecs[i].dv, t0s[i]);
      idle(vecs[i].gap);
    end
    wait_entries(6, 300);
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      check($sformatf("vec%0d_data", i), obs_q[i].data, vecs[i].exp_data);
      check($sformatf("vec%0d_ferr", i), obs_q[i].ferr, vecs[i].exp_ferr);
      check($sformatf("vec%0d_perr", i), obs_q[i].perr, vecs[i].exp_perr);
      check($sformatf("vec%0d_latency", i), obs_q[i].at - t0s[i], vecs[i].exp_lat);
    end

    // Start glitch: three low clocks must be rejected at the start sample.
    begin
      logic busy_seen = 1'b0;
      obs_q.delete();
      divisor = 16'd16;
      rxd = 1'b0;
      idle(3);
      rxd = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (busy) busy_seen = 1'b1;
      end
      check("glitch_busy_seen", busy_seen, 1'b1);
      check("glitch_busy_end", busy, 1'b0);
      check("glitch_rx_valid", rx_valid, 1'b0);
      check("glitch_no_push", obs_q.size(), 0);
    end

    // Framing error followed by a line held low (break).
    idle(2);
    obs_q.delete();
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 8, t0);
    idle(20);
    @(negedge clk);
    check("break_entries", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      check("break_data", obs_q[0].data, 8'h0F);
      check("break_ferr", obs_q[0].ferr, 1'b1);
    end
    check("break_busy", busy, 1'b1);
    rxd = 1'b1;
    idle(6);
    @(negedge clk);
    check("break_exit_busy", busy, 1'b0);
    check("break_no_second", obs_q.size(), 1);
    idle(4);

    // Overrun: five bytes into a four-entry FIFO with the consumer stalled.
    rx_ready = 1'b0;
    obs_q.delete();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, 1'b0, 8, t0);
      idle(4);
    end
    idle(10);
    @(negedge clk);
    check("ovr_flag", overrun, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("ovr_valid%0d", i), rx_valid, 1'b1);
      check($sformatf("ovr_data%0d", i), rx_data, 8'(i));
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
    end
    @(negedge clk);
    check("ovr_drained", rx_valid, 1'b0);
    check("ovr_sticky", overrun, 1'b1);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    @(negedge clk);
    check("ovr_cleared", overrun, 1'b0);

    // Reset during data bit 4 with two entries queued.
    idle(2);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 8, t0);
    idle(4);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 8, t0);
    idle(4);
    drive_bit(1'b0, 8);
    for (int k = 0; k < 4; k++) drive_bit(k[0], 8);
    drive_bit(1'b0, 3);
    @(negedge clk);
    check("rst_pre_valid", rx_valid, 1'b1);
    check("rst_pre_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rxd = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rx_ready = 1'b1;
    obs_q.delete();
    idle(10);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 8, t0);
    wait_entries(1, 40);
    idle(10);
    check("rst_after_entries", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q[0];
      check("rst_after_data", o.data, 8'h3C);
      check("rst_after_ferr", o.ferr, 1'b0);
      check("rst_after_latency", o.at - t0, 78);
    end

`ifdef UART_SERIAL_RX_PARITY_EN
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    obs_q.delete();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 8, t0);
    wait_entries(1, 40);
    if (obs_q.size() > 0) begin
      check("par_even_ok_perr", obs_q[0].perr, 1'b0);
      check("par_even_ok_data", obs_q[0].data, 8'h07);
      check("par_latency", obs_q[0].at - t0, 86);
    end
    idle(4);
    obs_q.delete();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 8, t0);
    wait_entries(1, 40);
    if (obs_q.size() > 0) check("par_even_bad_perr", obs_q[0].perr, 1'b1);
    idle(4);
    parity_odd = 1'b1;
    obs_q.delete();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 8, t0);
    wait_entries(1, 40);
    if (obs_q.size() > 0) check("par_odd_ok_perr", obs_q[0].perr, 1'b0);
    parity_en = 1'b0;
    idle(4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_serial_rx.md
# uart_serial_rx

Pad-side serial receiver that decodes the UART transmit line (`stx_pad_o`) of `wb_uart` back into bytes. It sits at the far end of the serial link in UART benches and SoC loopback paths, complementing the Wishbone master that drives the UART register side. Each frame is 8N1 (8 data bits, optional parity, 1 stop bit). Received bytes are buffered in a small FIFO with per-byte error flags and drained through a valid/ready handshake.

## Interface
- `DIV_WIDTH`, 16, width of the bit-period divisor.
- `FIFO_DEPTH`, 4, number of receive entries; must be a power of 2 and at least 2.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `rxd`  in  1  serial line, idle high; asynchronous to `clk`.
- `divisor`  in  DIV_WIDTH  clocks per bit; legal values are 4 or more.
- `parity_en`  in  1  frame carries a parity bit; used only when parity is compiled in.
- `parity_odd`  in  1  1 selects odd parity, 0 selects even.
- `rx_data`  out  8  byte at the FIFO head.
- `rx_frame_err`  out  1  head entry's stop bit was sampled 0.
- `rx_parity_err`  out  1  head entry failed the parity check.
- `rx_valid`  out  1  FIFO is not empty.
- `rx_ready`  in  1  consumer accepts the head entry.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `overrun_clr`  in  1  clears `overrun`.
- `busy`  out  1  receive FSM is not in IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer whose flops reset to 1. All behaviour below refers to the synchronized signal `rxs`.
- FSM states are IDLE, START, DATA, PARITY, STOP and BREAK.
- IDLE: on `rxs`==0, latch `divisor` into `div_q`, load the bit counter with `div_q>>1`, then go to START. A change to `divisor` mid-frame has no effect until the next start bit.
- The bit counter decrements once per clock. A sample is taken when it reaches 0, and the counter then reloads with `div_q-1`.
- START sample: if `rxs`==1, the start was a glitch; return to IDLE and push nothing. If `rxs`==0, go to DATA with bit index 0.
- DATA: take 8 samples, LSB first, shifting into `shreg`. After bit 7, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: sample the bit. `perr` = XOR of the 8 data bits, XOR the parity bit, XOR `parity_odd`. Nonzero means error for even parity; for odd parity, the `parity_odd` term inverts the result.
- STOP: sample the bit and set `ferr` = !`rxs`. Push {`shreg`, `ferr`, `perr`}. Then go to IDLE if `rxs`==1, or to BREAK if `rxs`==0.
- BREAK: wait for `rxs`==1, then return to IDLE. No start bit is detected while in BREAK.
- A push while the FIFO is full drops the new entry and sets `overrun`.
- If a push and `overrun_clr` occur in the same cycle, set wins.
- The FIFO pops when `rx_valid && rx_ready`.
- A push and a pop in the same cycle are both legal, including when the FIFO is full: the pop frees the slot, so no overrun occurs.
- Pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap naturally. Full is when the pointer MSBs differ and the remaining bits are equal.

## Timing
- Reset values: `rx_data`=0, both error flags 0, `rx_valid`=0, `overrun`=0, `busy`=0. The FSM is in IDLE and the FIFO is empty.
- Asserting `rst` mid-frame discards the partial byte and all FIFO contents on the next edge.
- Latency: a falling edge on `rxd` sampled at cycle T is seen in `rxs` at T+2.
- With `D` = `divisor`:
  - start sample at T+2+D/2,
  - data bit k sampled at T+2+D/2+(k+1)·D,
  - stop bit sampled at cycle S = T+2+D/2+9·D, or +10·D with parity.
- The entry is written at the edge ending cycle S, and `rx_valid` is high from S+1.
- `rx_data` and the error flags are stable while `rx_valid` is high and `rx_ready` is low.
- Back-to-back frames: because the FSM returns to IDLE at mid-stop-bit, a start bit immediately following a stop bit is detected without loss.

## Configuration
- Macro `UART_SERIAL_RX_PARITY_EN`.
- When defined: the PARITY state and checker are built, and `parity_en` and `parity_odd` take effect.
- When undefined: the PARITY state is removed, both parity inputs are ignored, `rx_parity_err` is tied to 0, and frames are always 8N1.

## Structure
- Package `uart_serial_rx_pkg` holds:
  - the `rx_state_e` enum (IDLE, START, DATA, PARITY, STOP, BREAK),
  - the `rx_entry_t` struct {data[7:0], frame_err, parity_err},
  - the `RX_ENTRY_W` constant (= 10).
- Sub-module `uart_serial_rx_fifo`: a synchronous FIFO of `rx_entry_t` with push, pop, full and empty, parameterized by `FIFO_DEPTH`.

## Test plan
- `divisor`=8, parity compiled out, send 0x55 then 0xA3 back-to-back:
  - `rx_valid` rises at S+1 of each frame,
  - `rx_data` = 0x55 then 0xA3,
  - both error flags stay 0.
- `divisor`=16, glitch low on `rxd` for 3 clocks: nothing is pushed, `busy` returns to 0, `rx_valid` stays 0.
- `divisor`=8, send 0x0F with the stop bit driven 0, and `rxd` held low 20 more clocks:
  - the entry holds 0x0F with `rx_frame_err`=1,
  - no second frame is detected until `rxd` returns high.
- `rx_ready`=0, send `FIFO_DEPTH`+1 bytes 0x01..0x05:
  - `overrun`=1, and the FIFO holds 0x01..0x04,
  - pulsing `overrun_clr` clears `overrun`.
- `UART_SERIAL_RX_PARITY_EN` defined, `parity_en`=1, `parity_odd`=0:
  - 0x07 with parity bit 1 gives `rx_parity_err`=0,
  - 0x07 with parity bit 0 gives `rx_parity_err`=1.
- Assert `rst` during data bit 4 of a frame with 2 entries queued: the next cycle shows `rx_valid`=0 and `busy`=0, and the following clean frame 0x3C is received correctly.
